sprite_dma_sequencer: RTL and testbench



---
 rtl/sprite_dma_sequencer.sv | 149 ++++++++++++++
 tb/tb_sprite_dma_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_dma_sequencer.sv
// Per-sprite vertical sequencer for the 8 sprite DMA channels: issues POS/CTL/DATA/DATB
// requests on sprite slots and decodes POS/CTL words into vstart/vstop.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_FETCH | POS/CTL words are fetched on this sprite's slots
// S_WAIT  | control loaded, waiting for vpos to reach vstart
// S_DATA  | live sprite lines, DATA/DATB fetched on this sprite's slots
// S_DONE  | no further fetches until the next vbl_end
module sprite_dma_sequencer #(
  parameter int VBITS = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [VBITS-1:0] vpos,
  input  logic             line_stb,
  input  logic             vbl_end,
  input  logic             slot_stb,
  input  logic [3:0]       slot,
  input  logic             spren,
  input  logic             dma_ack,
  input  logic [15:0]      data_in,
  output logic             dma_req,
  output logic [2:0]       dma_spr,
  output logic [1:0]       dma_reg,
  output logic [7:0]       spr_armed
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_DATA  = 2'd2,
    S_DONE  = 2'd3
  } spr_state_t;

  localparam logic [1:0] REG_POS = 2'd0;
  localparam logic [1:0] REG_CTL = 2'd1;

  spr_state_t       state_q  [8];
  spr_state_t       state_d  [8];
  logic [VBITS-1:0] vstart_q [8];
  logic [VBITS-1:0] vstart_d [8];
  logic [VBITS-1:0] vstop_q  [8];
  logic [VBITS-1:0] vstop_d  [8];

  logic             req_d;
  logic [2:0]       spr_d;
  logic [1:0]       reg_d;
  logic             ack_valid;
  logic [7:0]       ctl_hit;
  logic [2:0]       slot_spr;
  logic             slot_w;
  logic [VBITS-1:0] ctl_vstart;
  logic [VBITS-1:0] ctl_vstop;
  logic             unused_data;

  assign slot_spr    = slot[3:1];
  assign slot_w      = slot[0];
  assign ack_valid   = dma_req & dma_ack;
  assign unused_data = ^{data_in[7:3], data_in[0]};

  // Request for the slot arriving now; register selector holds when nothing is issued.
  always_comb begin
    req_d = 1'b0;
    spr_d = dma_spr;
    reg_d = dma_reg;
    if (slot_stb && spren) begin
      if (state_q[slot_spr] == S_FETCH) begin
        req_d = 1'b1;
        spr_d = slot_spr;
        reg_d = {1'b0, slot_w};
      end else if (state_q[slot_spr] == S_DATA) begin
        req_d = 1'b1;
        spr_d = slot_spr;
        reg_d = {1'b1, slot_w};
      end
    end
  end

  // CTL decode keeps the low byte of vstart that POS already delivered.
  always_comb begin
    ctl_vstart      = '0;
    ctl_vstart[7:0] = vstart_q[dma_spr][7:0];
    ctl_vstart[8]   = data_in[2];
    ctl_vstop       = '0;
    ctl_vstop[7:0]  = data_in[15:8];
    ctl_vstop[8]    = data_in[1];
  end

  always_comb begin
    ctl_hit = '0;
    for (int n = 0; n < 8; n++) begin
      ctl_hit[n] = ack_valid && (dma_reg == REG_CTL) && (dma_spr == 3'(n));
    end
  end

  always_comb begin
    for (int n = 0; n < 8; n++) begin
      state_d[n]  = state_q[n];
      vstart_d[n] = vstart_q[n];
      vstop_d[n]  = vstop_q[n];

      if (ack_valid && (dma_spr == 3'(n)) && (dma_reg == REG_POS)) begin
        vstart_d[n][7:0] = data_in[15:8];
      end

      if (ctl_hit[n]) begin
        vstart_d[n] = ctl_vstart;
        vstop_d[n]  = ctl_vstop;
        state_d[n]  = ((ctl_vstart == '0) && (ctl_vstop == '0)) ? S_DONE : S_WAIT;
      end else if (line_stb) begin
        if ((state_q[n] == S_DATA) && (vpos == vstop_q[n])) begin
          state_d[n] = S_FETCH;
        end else if ((state_q[n] == S_WAIT) && (vpos == vstart_q[n])) begin
          state_d[n] = S_DATA;
        end
      end

      if (vbl_end) begin
        state_d[n] = S_FETCH;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int n = 0; n < 8; n++) begin
        state_q[n]  <= S_DONE;
        vstart_q[n] <= '0;
        vstop_q[n]  <= '0;
      end
      dma_req   <= 1'b0;
      dma_spr   <= '0;
      dma_reg   <= '0;
      spr_armed <= '0;
    end else begin
      for (int n = 0; n < 8; n++) begin
        state_q[n]   <= state_d[n];
        vstart_q[n]  <= vstart_d[n];
        vstop_q[n]   <= vstop_d[n];
        spr_armed[n] <= (state_d[n] == S_DATA);
      end
      dma_req <= req_d;
      dma_spr <= spr_d;
      dma_reg <= reg_d;
    end
  end

endmodule

// File: tb/tb_sprite_dma_sequencer.sv
// Directed bench for sprite_dma_sequencer: a per-sprite behavioural model checked against
// the DUT every cycle, plus literal expectations at key points of the sequence.
module tb_sprite_dma_sequencer;

  localparam int VB = 9;
  localparam int ST_FETCH = 0;
  localparam int ST_WAIT  = 1;
  localparam int ST_DATA  = 2;
  localparam int ST_DONE  = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [VB-1:0] vpos;
  logic          line_stb;
  logic          vbl_end;
  logic          slot_stb;
  logic [3:0]    slot;
  logic          spren;
  logic          dma_ack;
  logic [15:0]   data_in;
  logic          dma_req;
  logic [2:0]    dma_spr;
  logic [1:0]    dma_reg;
  logic [7:0]    spr_armed;

  int tests = 0;
  int fails = 0;
  bit check_en = 1'b0;

  int         m_state  [8];
  int         m_vstart [8];
  int         m_vstop  [8];
  logic       m_req;
  logic [2:0] m_spr;
  logic [1:0] m_reg;
  logic [7:0] exp_arm;

  sprite_dma_sequencer #(.VBITS(VB)) dut (
    .clk(clk), .reset(reset), .vpos(vpos), .line_stb(line_stb), .vbl_end(vbl_end),
    .slot_stb(slot_stb), .slot(slot), .spren(spren), .dma_ack(dma_ack), .data_in(data_in),
    .dma_req(dma_req), .dma_spr(dma_spr), .dma_reg(dma_reg), .spr_armed(spr_armed)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Model: line compares use the old limits, then the acked word, then vbl_end, then the new slot.
  always @(posedge clk) begin
    int nxt [8];
    int ctl_spr;
    int s;
    if (reset) begin
      for (int n = 0; n < 8; n++) begin
        m_state[n] = ST_DONE; m_vstart[n] = 0; m_vstop[n] = 0;
      end
      m_req = 1'b0; m_spr = '0; m_reg = '0;
    end else begin
      for (int n = 0; n < 8; n++) nxt[n] = m_state[n];
      ctl_spr = (m_req && dma_ack && m_reg == 2'd1) ? int'(m_spr) : -1;
      if (line_stb) begin
        for (int n = 0; n < 8; n++) begin
          if (n != ctl_spr) begin
            if (m_state[n] == ST_DATA && int'(vpos) == m_vstop[n]) nxt[n] = ST_FETCH;
            else if (m_state[n] == ST_WAIT && int'(vpos) == m_vstart[n]) nxt[n] = ST_DATA;
          end
        end
      end
      if (m_req && dma_ack) begin
        s = int'(m_spr);
        if (m_reg == 2'd0) begin
          m_vstart[s] = (m_vstart[s] / 256) * 256 + int'(data_in[15:8]);
        end else if (m_reg == 2'd1) begin
          m_vstart[s] = (m_vstart[s] % 256) + 256 * int'(data_in[2]);
          m_vstop[s]  = int'(data_in[15:8]) + 256 * int'(data_in[1]);
          nxt[s] = (m_vstart[s] == 0 && m_vstop[s] == 0) ? ST_DONE : ST_WAIT;
        end
      end
      if (vbl_end) for (int n = 0; n < 8; n++) nxt[n] = ST_FETCH;
      if (slot_stb && spren &&
          (m_state[slot[3:1]] == ST_FETCH || m_state[slot[3:1]] == ST_DATA)) begin
        m_req = 1'b1;
        m_spr = slot[3:1];
        m_reg = ((m_state[slot[3:1]] == ST_DATA) ? 2'd2 : 2'd0) + {1'b0, slot[0]};
      end else begin
        m_req = 1'b0;
      end
      for (int n = 0; n < 8; n++) m_state[n] = nxt[n];
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      for (int n = 0; n < 8; n++) exp_arm[n] = (m_state[n] == ST_DATA);
      chk("cyc_dma_req", int'(dma_req), int'(m_req));
      chk("cyc_dma_spr", int'(dma_spr), int'(m_spr));
      chk("cyc_dma_reg", int'(dma_reg), int'(m_reg));
      chk("cyc_spr_armed", int'(spr_armed), int'(exp_arm));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    slot_stb = 1'b0; line_stb = 1'b0; vbl_end = 1'b0; dma_ack = 1'b0;
  endtask

  task automatic do_line(input int v);
    vpos = VB'(v);
    line_stb = 1'b1;
    cyc();
  endtask

  task automatic do_slot(input logic [3:0] s, input logic ack, input logic [15:0] d,
                         input logic exp_req, input logic [1:0] exp_reg);
    slot = s;
    slot_stb = 1'b1;
    cyc();
    chk("slot_req", int'(dma_req), int'(exp_req));
    if (exp_req) begin
      chk("slot_spr", int'(dma_spr), int'(s[3:1]));
      chk("slot_reg", int'(dma_reg), int'(exp_reg));
    end
    dma_ack = ack;
    data_in = d;
    cyc();
  endtask

  initial begin
    reset = 1'b1; vpos = '0; line_stb = 1'b0; vbl_end = 1'b0; slot_stb = 1'b0;
    slot = '0; spren = 1'b1; dma_ack = 1'b0; data_in = '0;
    cyc();
    check_en = 1'b1;
    cyc();
    chk("rst_req", int'(dma_req), 0);
    chk("rst_spr", int'(dma_spr), 0);
    chk("rst_reg", int'(dma_reg), 0);
    chk("rst_armed", int'(spr_armed), 0);
    reset = 1'b0;

    vbl_end = 1'b1;
    cyc();

    // Line 25: control fetches for sprites 0, 3, 5 (CTL stolen) and 1.
    do_line('h19);
    do_slot(4'd0, 1'b1, 16'h3000, 1'b1, 2'd0);
    do_slot(4'd1, 1'b1, 16'h4000, 1'b1, 2'd1);
    do_slot(4'd6, 1'b1, 16'h0000, 1'b1, 2'd0);
    do_slot(4'd7, 1'b1, 16'h0000, 1'b1, 2'd1);
    do_slot(4'd10, 1'b1, 16'h5000, 1'b1, 2'd0);
    do_slot(4'd11, 1'b0, 16'h6000, 1'b1, 2'd1);
    do_slot(4'd2, 1'b1, 16'h0000, 1'b1, 2'd0);
    do_slot(4'd3, 1'b1, 16'h0006, 1'b1, 2'd1);
    chk("m_vstart0", m_vstart[0], 'h030);
    chk("m_vstop0", m_vstop[0], 'h040);
    chk("m_vstart1", m_vstart[1], 'h100);
    chk("m_vstop1", m_vstop[1], 'h100);
    chk("m_state1", m_state[1], ST_WAIT);
    chk("m_state3", m_state[3], ST_DONE);
    chk("m_state5", m_state[5], ST_FETCH);

    // Line 26: sprite 5 refetches and completes; DONE/WAIT sprites stay silent.
    do_line('h1A);
    do_slot(4'd10, 1'b1, 16'h5000, 1'b1, 2'd0);
    do_slot(4'd11, 1'b1, 16'h6000, 1'b1, 2'd1);
    do_slot(4'd6, 1'b1, 16'h1234, 1'b0, 2'd0);
    do_slot(4'd0, 1'b1, 16'h1234, 1'b0, 2'd0);
    chk("m_state5_wait", m_state[5], ST_WAIT);

    do_line('h30);
    chk("armed_0x30", int'(spr_armed), 'h01);
    do_slot(4'd0, 1'b1, 16'hAAAA, 1'b1, 2'd2);
    do_slot(4'd1, 1'b1, 16'h5555, 1'b1, 2'd3);
    for (int v = 'h31; v <= 'h3F; v++) begin
      spren = !(v >= 'h35 && v <= 'h37);
      do_line(v);
      do_slot(4'd0, 1'b1, 16'hAAAA, spren, 2'd2);
      do_slot(4'd1, 1'b1, 16'h5555, spren, 2'd3);
      chk("armed_data", int'(spr_armed), 'h01);
    end
    spren = 1'b1;

    do_line('h40);
    chk("armed_0x40", int'(spr_armed), 'h00);
    do_slot(4'd0, 1'b1, 16'h4800, 1'b1, 2'd0);
    do_slot(4'd1, 1'b1, 16'h4C00, 1'b1, 2'd1);
    do_line('h48);
    chk("armed_0x48", int'(spr_armed), 'h01);
    do_line('h4C);
    chk("armed_0x4C", int'(spr_armed), 'h00);
    do_line('h50);
    chk("armed_0x50", int'(spr_armed), 'h20);
    do_slot(4'd10, 1'b1, 16'h0F0F, 1'b1, 2'd2);

    // vstart == vstop == 0x100: enters DATA and stays for the rest of the frame.
    do_line('h100);
    chk("armed_0x100", int'(spr_armed), 'h22);
    do_slot(4'd0, 1'b1, 16'h0200, 1'b1, 2'd0);

    // CTL ack lands in the same cycle as line_stb.
    slot = 4'd1;
    slot_stb = 1'b1;
    cyc();
    chk("same_req", int'(dma_req), 1);
    chk("same_reg", int'(dma_reg), 1);
    dma_ack = 1'b1; data_in = 16'h0306; vpos = VB'('h102); line_stb = 1'b1;
    cyc();
    chk("m_vstart0_b", m_vstart[0], 'h102);
    chk("m_vstop0_b", m_vstop[0], 'h103);
    chk("armed_same", int'(spr_armed), 'h22);
    do_line('h102);
    chk("armed_0x102", int'(spr_armed), 'h23);

    // vbl_end together with a vstop match.
    vpos = VB'('h103); line_stb = 1'b1; vbl_end = 1'b1;
    cyc();
    chk("armed_vbl", int'(spr_armed), 'h00);
    do_slot(4'd6, 1'b0, 16'h0000, 1'b1, 2'd0);

    // Mid-frame reset with a slot pending.
    do_line('h19);
    do_slot(4'd0, 1'b1, 16'h3000, 1'b1, 2'd0);
    do_slot(4'd1, 1'b1, 16'h4000, 1'b1, 2'd1);
    reset = 1'b1; slot = 4'd12; slot_stb = 1'b1;
    cyc();
    chk("mrst_req", int'(dma_req), 0);
    chk("mrst_spr", int'(dma_spr), 0);
    chk("mrst_reg", int'(dma_reg), 0);
    chk("mrst_armed", int'(spr_armed), 0);
    reset = 1'b0;
    do_slot(4'd0, 1'b1, 16'h3000, 1'b0, 2'd0);
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
